// File: rtl/systolic_mma_nxn_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the N x N output-stationary systolic matrix engine:
//   - state_e   : control FSM state encoding (IDLE, FEED, FLUSH, DONE)
//   - acc_w_f   : accumulator width derivation (2*DATA_W + clog2(K_MAX))
//   - flat_idx  : row/column -> slice index for the flat C result vector
// No ports (package).
// -----------------------------------------------------------------------------
package systolic_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N      = 4;
  localparam int DEF_K_MAX  = 16;

  // Wide enough to hold K_MAX full-scale products without wrap.
  function automatic int acc_w_f(input int data_w, input int k_max);
    return 2 * data_w + $clog2(k_max);
  endfunction

  // C[row][col] lives at slice row*n+col of the flat result vector.
  function automatic int flat_idx(input int row, input int col, input int n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/systolic_mma_nxn_if.sv
// -----------------------------------------------------------------------------
// systolic_mma_nxn_if
// Bundles the job, operand-stream and result handshakes of systolic_mma_nxn.
//   start/k_len    : job request (k_len sampled with start, only in IDLE)
//   busy           : engine not in IDLE
//   in_valid/in_ready, a_in, b_in : operand beats (A column / B row per beat)
//   c_valid/c_ready, c_out         : result matrix hand-off
//   dbg_state      : current control FSM state, for observation only
// Modports: master = operand streamer / writeback side, slave = engine.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. The producer holds data stable while
// valid=1 and ready=0; ready may be asserted independently of valid.
// -----------------------------------------------------------------------------
interface systolic_mma_nxn_if #(
  parameter int DATA_W = systolic_pkg::DEF_DATA_W,
  parameter int N      = systolic_pkg::DEF_N,
  parameter int K_MAX  = systolic_pkg::DEF_K_MAX,
  parameter int ACC_W  = systolic_pkg::acc_w_f(DATA_W, K_MAX)
) ();

  logic                         start;
  logic [$clog2(K_MAX+1)-1:0]   k_len;
  logic                         busy;
  logic                         in_valid;
  logic                         in_ready;
  logic [N*DATA_W-1:0]          a_in;
  logic [N*DATA_W-1:0]          b_in;
  logic                         c_valid;
  logic                         c_ready;
  logic [N*N*ACC_W-1:0]         c_out;
  systolic_pkg::state_e         dbg_state;

  modport master (
    output start, k_len, in_valid, a_in, b_in, c_ready,
    input  busy, in_ready, c_valid, c_out, dbg_state
  );

  modport slave (
    input  start, k_len, in_valid, a_in, b_in, c_ready,
    output busy, in_ready, c_valid, c_out, dbg_state
  );

endinterface

// File: rtl/systolic_mma_nxn_pe.sv
// -----------------------------------------------------------------------------
// systolic_pe
// One processing element of the output-stationary mesh. Registers A to the
// right and B downward (with their valid tags) and accumulates a*b whenever
// both incoming tags are set, so zero bubbles never touch the accumulator.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   i_clr               : synchronous accumulator clear (start of job)
//   i_a, i_a_vld        : A operand + tag from the left
//   i_b, i_b_vld        : B operand + tag from above
//   o_a, o_a_vld        : registered A + tag to the right neighbour
//   o_b, o_b_vld        : registered B + tag to the neighbour below
//   o_acc               : accumulator value
// Build option: SYSTOLIC_SIGNED_EN selects two's complement operands with a
// sign-extended product; otherwise operands are unsigned, zero-extended.
// -----------------------------------------------------------------------------
module systolic_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_a,
  input  logic              i_a_vld,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_b_vld,
  output logic [DATA_W-1:0] o_a,
  output logic              o_a_vld,
  output logic [DATA_W-1:0] o_b,
  output logic              o_b_vld,
  output logic [ACC_W-1:0]  o_acc
);

  localparam int PW = 2 * DATA_W;

  logic [PW-1:0]     w_prod;
  logic [ACC_W-1:0]  w_prod_ext;

  logic [DATA_W-1:0] r_a;
  logic              r_a_vld;
  logic [DATA_W-1:0] r_b;
  logic              r_b_vld;
  logic [ACC_W-1:0]  r_acc;

`ifdef SYSTOLIC_SIGNED_EN
  // Low PW bits of the product of sign-extended operands equal the signed product.
  assign w_prod     = {{DATA_W{i_a[DATA_W-1]}}, i_a} * {{DATA_W{i_b[DATA_W-1]}}, i_b};
  assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
`else
  assign w_prod     = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
  assign w_prod_ext = {{(ACC_W-PW){1'b0}}, w_prod};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_a_vld <= 1'b0;
      r_b     <= '0;
      r_b_vld <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_a     <= i_a;
      r_a_vld <= i_a_vld;
      r_b     <= i_b;
      r_b_vld <= i_b_vld;
      if (i_clr) begin
        r_acc <= '0;
      end else if (i_a_vld && i_b_vld) begin
        r_acc <= r_acc + w_prod_ext;
      end
    end
  end

  assign o_a     = r_a;
  assign o_a_vld = r_a_vld;
  assign o_b     = r_b;
  assign o_b_vld = r_b_vld;
  assign o_acc   = r_acc;

endmodule

// File: rtl/systolic_mma_nxn.sv
// -----------------------------------------------------------------------------
// systolic_mma_nxn
// N x N output-stationary systolic engine computing C = A x B, with A (N x K)
// streamed one column per beat and B (K x N) one row per beat, K <= K_MAX.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset (clears FSM, skew, mesh, counters)
//   bus    : systolic_mma_nxn_if.slave -- start/k_len/busy, in_valid/in_ready
//            with a_in/b_in, c_valid/c_ready with c_out, dbg_state
// Build option: SYSTOLIC_SIGNED_EN (two's complement arithmetic in the PEs).
// The N/DATA_W/K_MAX/ACC_W parameters must match those of the bound interface.
//
// Timing: beat k accepted at edge E reaches PE(i,j) at edge E+i+j through the
// input skew chains plus the PE pass-through registers. The last PE finishes
// at E+2N-2, so FLUSH spans 2N-1 cycles and c_valid rises at edge E+2N-1.
// -----------------------------------------------------------------------------
module systolic_mma_nxn
  import systolic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N      = DEF_N,
  parameter int K_MAX  = DEF_K_MAX,
  parameter int ACC_W  = acc_w_f(DATA_W, K_MAX)
) (
  input  logic               clk,
  input  logic               reset,
  systolic_mma_nxn_if.slave  bus
);

  localparam int KW  = $clog2(K_MAX + 1);
  localparam int FCW = $clog2(2 * N);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_e          r_state;
  logic [KW-1:0]   r_k_len;
  logic [KW-1:0]   r_beat_cnt;
  logic [FCW-1:0]  r_flush_cnt;
  logic            r_busy;
  logic            r_in_ready;
  logic            r_c_valid;

  logic [KW-1:0]   w_k_clamp;
  logic            w_beat;
  logic            w_clr;

  assign w_k_clamp = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
  // r_in_ready is high exactly in FEED, so this is the accepted-beat strobe.
  assign w_beat    = r_in_ready & bus.in_valid;
  assign w_clr     = (r_state == S_IDLE) & bus.start;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_c_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_k_len    <= w_k_clamp;
            r_beat_cnt <= '0;
            r_busy     <= 1'b1;
            if (w_k_clamp == '0) begin
              r_state   <= S_DONE;
              r_c_valid <= 1'b1;
            end else begin
              r_state    <= S_FEED;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_FEED: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + KW'(1);
            if (r_beat_cnt + KW'(1) == r_k_len) begin
              r_state     <= S_FLUSH;
              r_in_ready  <= 1'b0;
              r_flush_cnt <= '0;
            end
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == FCW'(2 * N - 2)) begin
            r_state   <= S_DONE;
            r_c_valid <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt + FCW'(1);
          end
        end
        S_DONE: begin
          if (bus.c_ready) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_c_valid <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b0;
          r_c_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.in_ready  = r_in_ready;
  assign bus.c_valid   = r_c_valid;
  assign bus.dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Mesh wiring. Column index N of w_a_h and row index N of w_b_v collect the
  // outputs leaving the far edges of the array; nothing downstream uses them.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_a_h  [N][N+1];
  logic              w_av_h [N][N+1];
  logic [DATA_W-1:0] w_b_v  [N+1][N];
  logic              w_bv_v [N+1][N];
  logic [ACC_W-1:0]  w_acc  [N][N];

  // ---------------------------------------------------------------------------
  // Input skew: row i of A is delayed i cycles, column j of B j cycles.
  // Non-beat cycles push zeros with a cleared tag so the alignment between
  // the A and B wavefronts is kept while the pipeline shifts every cycle.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [DATA_W-1:0] w_a_gate;
    logic [DATA_W-1:0] w_b_gate;

    assign w_a_gate = w_beat ? bus.a_in[gi*DATA_W +: DATA_W] : '0;
    assign w_b_gate = w_beat ? bus.b_in[gi*DATA_W +: DATA_W] : '0;

    if (gi == 0) begin : g_direct
      assign w_a_h[gi][0]  = w_a_gate;
      assign w_av_h[gi][0] = w_beat;
      assign w_b_v[0][gi]  = w_b_gate;
      assign w_bv_v[0][gi] = w_beat;
    end else begin : g_chain
      logic [DATA_W-1:0] r_a_sh  [gi];
      logic              r_av_sh [gi];
      logic [DATA_W-1:0] r_b_sh  [gi];
      logic              r_bv_sh [gi];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int s = 0; s < gi; s++) begin
            r_a_sh[s]  <= '0;
            r_av_sh[s] <= 1'b0;
            r_b_sh[s]  <= '0;
            r_bv_sh[s] <= 1'b0;
          end
        end else begin
          r_a_sh[0]  <= w_a_gate;
          r_av_sh[0] <= w_beat;
          r_b_sh[0]  <= w_b_gate;
          r_bv_sh[0] <= w_beat;
          for (int s = 1; s < gi; s++) begin
            r_a_sh[s]  <= r_a_sh[s-1];
            r_av_sh[s] <= r_av_sh[s-1];
            r_b_sh[s]  <= r_b_sh[s-1];
            r_bv_sh[s] <= r_bv_sh[s-1];
          end
        end
      end

      assign w_a_h[gi][0]  = r_a_sh[gi-1];
      assign w_av_h[gi][0] = r_av_sh[gi-1];
      assign w_b_v[0][gi]  = r_b_sh[gi-1];
      assign w_bv_v[0][gi] = r_bv_sh[gi-1];
    end
  end

  // ---------------------------------------------------------------------------
  // N x N PE mesh
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      systolic_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_clr),
        .i_a     (w_a_h[gi][gj]),
        .i_a_vld (w_av_h[gi][gj]),
        .i_b     (w_b_v[gi][gj]),
        .i_b_vld (w_bv_v[gi][gj]),
        .o_a     (w_a_h[gi][gj+1]),
        .o_a_vld (w_av_h[gi][gj+1]),
        .o_b     (w_b_v[gi+1][gj]),
        .o_b_vld (w_bv_v[gi+1][gj]),
        .o_acc   (w_acc[gi][gj])
      );
    end
  end

  // Accumulators are quiescent once the tags have drained, so c_out is stable
  // for the whole of DONE and until the next job's clear.
  logic [N*N*ACC_W-1:0] w_c_flat;

  always_comb begin
    w_c_flat = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w_c_flat[flat_idx(i, j, N)*ACC_W +: ACC_W] = w_acc[i][j];
      end
    end
  end

  assign bus.c_out = w_c_flat;

endmodule

// File: tb/tb_systolic_mma_nxn.sv
// -----------------------------------------------------------------------------
// tb_systolic_mma_nxn
// Self-checking bench for systolic_mma_nxn: directed jobs (identity, full
// range, bubbles + backpressure, zero length, mid-job reset, signed cases
// under SYSTOLIC_SIGNED_EN) and randomized jobs against a plain-arithmetic
// matrix product model. Expected matrices go into exp_q at job issue; a
// monitor pops and compares on every c_valid & c_ready.
// -----------------------------------------------------------------------------
module tb_systolic_mma_nxn;
  import systolic_pkg::*;

  localparam int DATA_W = 8;
  localparam int N      = 4;
  localparam int K_MAX  = 16;
  localparam int ACC_W  = acc_w_f(DATA_W, K_MAX);
  localparam int KW     = $clog2(K_MAX + 1);
  localparam int CW     = N * N * ACC_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_mma_nxn_if #(.DATA_W(DATA_W), .N(N), .K_MAX(K_MAX), .ACC_W(ACC_W)) u_if ();

  systolic_mma_nxn #(
    .DATA_W (DATA_W),
    .N      (N),
    .K_MAX  (K_MAX),
    .ACC_W  (ACC_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [CW-1:0] exp_q[$];

  logic [DATA_W-1:0] a_m [N][K_MAX];
  logic [DATA_W-1:0] b_m [K_MAX][N];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], kept to ACC_W bits.
  function automatic logic [CW-1:0] ref_c(input int k);
    logic [CW-1:0] c;
    longint s, av, bv;
    c = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) begin
`ifdef SYSTOLIC_SIGNED_EN
          av = longint'($signed(a_m[i][kk]));
          bv = longint'($signed(b_m[kk][j]));
`else
          av = longint'(a_m[i][kk]);
          bv = longint'(b_m[kk][j]);
`endif
          s += av * bv;
        end
        c[(i*N+j)*ACC_W +: ACC_W] = s[ACC_W-1:0];
      end
    end
    return c;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset && u_if.c_valid && u_if.c_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got a result, expected none queued (t=%0t)", $time);
      end else begin
        logic [CW-1:0] e;
        e = exp_q.pop_front();
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            check($sformatf("c[%0d][%0d]", i, j),
                  longint'(u_if.c_out[(i*N+j)*ACC_W +: ACC_W]),
                  longint'(e[(i*N+j)*ACC_W +: ACC_W]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic start_job(input int k);
    u_if.start = 1'b1;
    u_if.k_len = KW'(k);
    @(posedge clk);
    #1 u_if.start = 1'b0;
    u_if.k_len = KW'($urandom_range(0, K_MAX));
  endtask

  // mode 0: valid every cycle, 1: pattern 1,0,0,..., 2: random
  task automatic feed(input int k_eff, input int mode);
    int beat = 0;
    int cyc  = 0;
    bit acc;
    while (beat < k_eff && cyc < 2000) begin
      u_if.in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        u_if.a_in[i*DATA_W +: DATA_W] = u_if.in_valid ? a_m[i][beat] : DATA_W'($urandom);
        u_if.b_in[i*DATA_W +: DATA_W] = u_if.in_valid ? b_m[beat][i] : DATA_W'($urandom);
      end
      @(negedge clk);
      if (cyc == 0) check("feed_in_ready", u_if.in_ready, 1);
      acc = u_if.in_valid && u_if.in_ready;
      @(posedge clk);
      #1;
      if (acc) beat++;
      cyc++;
    end
    u_if.in_valid = 1'b0;
    if (beat < k_eff) check("feed_timeout", beat, k_eff);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (u_if.busy && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("back_to_idle", u_if.busy, 0);
  endtask

  task automatic run_job(input int k, input int mode, input bit bp);
    int k_eff;
    int m;
    bit ready_bad;
    bit moved;
    logic [CW-1:0] snap;
    k_eff = (k > K_MAX) ? K_MAX : k;
    @(negedge clk);
    check("idle_in_ready", u_if.in_ready, 0);
    @(posedge clk);
    #1;
    u_if.c_ready = !bp;
    exp_q.push_back(ref_c(k_eff));
    start_job(k);
    if (k_eff == 0) begin
      @(negedge clk);
      check("zero_len_done", u_if.c_valid, 1);
      @(posedge clk);
      #1;
    end else begin
      feed(k_eff, mode);
      m = 0;
      ready_bad = 0;
      do begin
        @(negedge clk);
        m++;
        if (u_if.in_ready) ready_bad = 1;
      end while (!u_if.c_valid && m < 200);
      check("latency_edges", m - 1, 2 * N - 1);
      check("in_ready_flush", ready_bad, 0);
      if (bp) begin
        snap  = u_if.c_out;
        moved = 0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (!u_if.c_valid || u_if.c_out != snap) moved = 1;
        end
        check("bp_hold_stable", moved, 0);
        @(posedge clk);
        #1 u_if.c_ready = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    wait_idle();
  endtask

  task automatic load_identity();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) a_m[i][k] = (i == k) ? DATA_W'(1) : '0;
    for (int k = 0; k < K_MAX; k++)
      for (int j = 0; j < N; j++) b_m[k][j] = DATA_W'(k * N + j + 1);
  endtask

  task automatic load_const(input int av, input int bv);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) a_m[i][k] = DATA_W'(av);
    for (int k = 0; k < K_MAX; k++)
      for (int j = 0; j < N; j++) b_m[k][j] = DATA_W'(bv);
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) a_m[i][k] = DATA_W'($urandom);
    for (int k = 0; k < K_MAX; k++)
      for (int j = 0; j < N; j++) b_m[k][j] = DATA_W'($urandom);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset         = 1'b1;
    u_if.start    = 1'b0;
    u_if.k_len    = '0;
    u_if.in_valid = 1'b0;
    u_if.a_in     = '0;
    u_if.b_in     = '0;
    u_if.c_ready  = 1'b1;

    do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", u_if.busy, 0);
    check("rst_in_ready", u_if.in_ready, 0);
    check("rst_c_valid", u_if.c_valid, 0);
    check("rst_c_out_zero", (u_if.c_out == '0), 1);
    check("rst_state", u_if.dbg_state, S_IDLE);
    @(posedge clk);
    #1 reset = 1'b0;

    // Identity: C must equal B.
    load_identity();
    run_job(4, 0, 0);

    // Full range: 255*255*16 = 1040400 per element, fits in ACC_W.
    load_const(255, 255);
    run_job(16, 0, 0);

    // Bubbles (1,0,0,...) plus 5 cycles of result backpressure.
    load_identity();
    run_job(4, 1, 1);

    // Zero-length job yields an all-zero result after one cycle.
    load_random();
    run_job(0, 0, 0);

    // Mid-job reset after two beats, then a clean job.
    load_random();
    start_job(4);
    feed(2, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", u_if.busy, 0);
    check("midrst_in_ready", u_if.in_ready, 0);
    check("midrst_c_valid", u_if.c_valid, 0);
    check("midrst_c_out_zero", (u_if.c_out == '0), 1);
    check("midrst_state", u_if.dbg_state, S_IDLE);
    @(posedge clk);
    #1 reset = 1'b0;
    load_identity();
    run_job(4, 0, 0);

`ifdef SYSTOLIC_SIGNED_EN
    load_const(-128, -128);
    run_job(4, 0, 0);
    load_const(-1, 3);
    run_job(2, 2, 0);
`endif

    // Randomized jobs, including one with k_len above K_MAX (clamped).
    for (int t = 0; t < 8; t++) begin
      load_random();
      run_job($urandom_range(1, K_MAX), 2, ($urandom_range(0, 3) == 0));
    end
    load_random();
    run_job(K_MAX + 4, 2, 0);

    repeat (5) @(posedge clk);
    check("results_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
